gate_bist_ctrl: RTL and testbench

Self-test sequencer for the switch-level gate unit (NOT/NAND/NOR/AND/OR/XOR/XNOR). On a start request it drives all four `{x, y}` input vectors into the gate unit and waits a programmable settle time per vector. It then samples the seven gate outputs, compares them against the golden truth table and reports per-gate and per-vector failures with a pass/done summary. It sits between the system control logic and the gate unit and owns the unit's `x`/`y` inputs while busy.

---
 rtl/gate_bist_ctrl.sv | 151 +++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// +--------------------------------------------------------------------------+
// | gate_bist_ctrl: self-test sequencer for the seven-gate switch-level unit |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module gate_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] gate_out,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_mask,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] C_CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_vec, w_vec_nxt, w_vec_inc;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_x_nxt, w_y_nxt, w_busy_nxt, w_done_nxt, w_pass_nxt;
  logic [6:0] w_err_nxt, w_golden, w_mism;
  logic [3:0] w_fail_nxt;
  logic       w_abort_hit;

  // Golden truth table evaluated on the vector currently driven into the unit.
  assign w_golden    = {~x, ~(x & y), ~(x | y), x & y, x | y, x ^ y, ~(x ^ y)};
  assign w_mism      = gate_out ^ w_golden;
  assign w_vec_inc   = r_vec + 2'd1;
  assign w_abort_hit = abort && (r_state == ST_SETTLE || r_state == ST_SAMPLE);

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = x;
    w_y_nxt     = y;
    w_busy_nxt  = busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = pass;
    w_err_nxt   = err_mask;
    w_fail_nxt  = fail_vec;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_vec_nxt   = 2'd0;
          w_cnt_nxt   = 4'd0;
          w_x_nxt     = 1'b0;
          w_y_nxt     = 1'b0;
          w_busy_nxt  = 1'b1;
          w_pass_nxt  = 1'b0;
          w_err_nxt   = 7'd0;
          w_fail_nxt  = 4'd0;
        end
      end
      ST_SETTLE: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        w_err_nxt         = err_mask | w_mism;
        w_fail_nxt[r_vec] = |w_mism;
        if (r_vec != 2'd3) begin
          w_state_nxt = ST_SETTLE;
          w_vec_nxt   = w_vec_inc;
          w_cnt_nxt   = 4'd0;
          w_x_nxt     = w_vec_inc[1];
          w_y_nxt     = w_vec_inc[0];
        end else begin
          // Pass must include the final vector's mismatches sampled on this edge.
          w_state_nxt = ST_DONE;
          w_vec_nxt   = 2'd0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = ((err_mask | w_mism) == 7'd0);
          w_x_nxt     = 1'b0;
          w_y_nxt     = 1'b0;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the sample step would have recorded.
    if (w_abort_hit) begin
      w_state_nxt = ST_IDLE;
      w_vec_nxt   = 2'd0;
      w_cnt_nxt   = 4'd0;
      w_x_nxt     = 1'b0;
      w_y_nxt     = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_pass_nxt  = 1'b0;
      w_err_nxt   = 7'd0;
      w_fail_nxt  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_vec    <= 2'd0;
      r_cnt    <= 4'd0;
      x        <= 1'b0;
      y        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_mask <= 7'd0;
      fail_vec <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_vec    <= w_vec_nxt;
      r_cnt    <= w_cnt_nxt;
      x        <= w_x_nxt;
      y        <= w_y_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      pass     <= w_pass_nxt;
      err_mask <= w_err_nxt;
      fail_vec <= w_fail_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_gate_bist_ctrl: bench for gate_bist_ctrl with a fault-injecting unit  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, sel;
  logic [6:0] inject [4];
  int         total = 0;
  int         passed = 0;
  int         cyc = 0;
  int         last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Truth-table columns indexed by {x,y}, one nibble per gate, not_x first.
  function automatic logic [6:0] ideal(input logic [1:0] v);
    logic [27:0] tt;
    logic [6:0]  r;
    tt = {4'b0011, 4'b0111, 4'b0001, 4'b1000, 4'b1110, 4'b0110, 4'b1001};
    for (int g = 0; g < 7; g++) r[g] = tt[4*g + int'(v)];
    return r;
  endfunction

  logic       x2, y2, busy2, done2, pass2, x1, y1, busy1, done1, pass1;
  logic [6:0] err2, err1, gate2, gate1;
  logic [3:0] fail2, fail1;
  logic       start2, start1, abort2, abort1;

  assign start2 = start & ~sel;
  assign start1 = start & sel;
  assign abort2 = abort & ~sel;
  assign abort1 = abort & sel;
  assign gate2  = ideal({x2, y2}) ^ inject[{x2, y2}];
  assign gate1  = ideal({x1, y1}) ^ inject[{x1, y1}];

  gate_bist_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .gate_out(gate2),
    .x(x2), .y(y2), .busy(busy2), .done(done2), .pass(pass2),
    .err_mask(err2), .fail_vec(fail2));

  gate_bist_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .gate_out(gate1),
    .x(x1), .y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .err_mask(err1), .fail_vec(fail1));

  logic       o_x, o_y, o_busy, o_done, o_pass;
  logic [6:0] o_err;
  logic [3:0] o_fail;
  assign o_x    = sel ? x1    : x2;
  assign o_y    = sel ? y1    : y2;
  assign o_busy = sel ? busy1 : busy2;
  assign o_done = sel ? done1 : done2;
  assign o_pass = sel ? pass1 : pass2;
  assign o_err  = sel ? err1  : err2;
  assign o_fail = sel ? fail1 : fail2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_xy"},   {30'd0, o_x, o_y}, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_err"},  o_err, 0);
    chk({tag, "_fail"}, o_fail, 0);
  endtask

  // One full run from IDLE; expectations come from the injected fault table.
  task automatic run(input int s, input bit mid_start, input bit hold_start);
    logic [6:0] e_err;
    logic [3:0] e_fail;
    int         n, acc;
    e_err  = 7'd0;
    e_fail = 4'd0;
    for (int v = 0; v < 4; v++) begin
      e_err     |= inject[v];
      e_fail[v]  = |inject[v];
    end
    n = 4 * (s + 1);
    start = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    acc = cyc;
    chk("accept_err_clr",  o_err, 0);
    chk("accept_fail_clr", o_fail, 0);
    chk("accept_pass_clr", o_pass, 0);
    for (int k = 0; k < n; k++) begin
      chk("run_busy", o_busy, 1);
      chk("run_xy",   {30'd0, o_x, o_y}, k / (s + 1));
      chk("run_done", o_done, 0);
      if (mid_start) start = (k == n / 2);
      step();
    end
    start = hold_start;
    chk("done_pulse",   o_done, 1);
    chk("done_busy",    o_busy, 0);
    chk("done_xy",      {30'd0, o_x, o_y}, 0);
    chk("done_pass",    o_pass, (e_err == 7'd0));
    chk("done_err",     o_err, e_err);
    chk("done_fail",    o_fail, e_fail);
    chk("done_latency", cyc - acc, n);
    if (hold_start && last_done != 0) chk("done_period", cyc - last_done, n + 2);
    last_done = cyc;
    step();
    chk("idle_done", o_done, 0);
    chk("idle_busy", o_busy, 0);
    chk("idle_pass_hold", o_pass, (e_err == 7'd0));
    chk("idle_err_hold",  o_err, e_err);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
    for (int v = 0; v < 4; v++) inject[v] = 7'd0;
    step(); step();
    chk_all_zero("por_s2");
    sel = 1'b1;
    chk_all_zero("por_s1");
    sel = 1'b0;
    rst_n = 1'b1;
    step();
    chk_all_zero("idle_s2");

    // Good unit.
    run(2, 0, 0);
    chk("good_pass", o_pass, 1);

    // And output stuck at 1.
    for (int v = 0; v < 4; v++) inject[v] = 7'b0001000 & ~ideal(2'(v));
    run(2, 0, 0);
    chk("stuck_err",  o_err, 7'b0001000);
    chk("stuck_fail", o_fail, 4'b0111);

    // Xor inverted plus not_x stuck at 0.
    for (int v = 0; v < 4; v++) inject[v] = 7'b0000010 | (7'b1000000 & ideal(2'(v)));
    run(2, 0, 0);
    chk("multi_err",  o_err, 7'b1000010);
    chk("multi_fail", o_fail, 4'b1111);

    for (int v = 0; v < 4; v++) inject[v] = 7'd0;
    run(2, 0, 0);
    chk("rerun_pass", o_pass, 1);

    // Start re-pulsed mid-run, then held continuously.
    inject[2] = 7'b0100000;
    run(2, 1, 0);
    last_done = 0;
    for (int r = 0; r < 3; r++) run(2, 0, 1);
    start = 1'b0;
    step();

    // Reset mid-run after faults have been recorded.
    inject[0] = 7'b0000100;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("pre_reset_err", o_err, inject[0]);
    rst_n = 1'b0;
    step();
    chk_all_zero("midrst_a");
    step();
    chk_all_zero("midrst_b");
    rst_n = 1'b1;
    step();
    chk_all_zero("midrst_idle");

    // Randomized fault patterns on both settle lengths.
    for (int i = 0; i < 10; i++) begin
      sel = 1'($urandom);
      for (int v = 0; v < 4; v++)
        inject[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      run(sel ? 1 : 2, 0, 0);
    end

    // Abort during the vec=2 SAMPLE cycle with SETTLE_CYCLES=1.
    sel = 1'b1;
    inject[0] = 7'b0010001; inject[1] = 7'b0000000;
    inject[2] = 7'b1100000; inject[3] = 7'b0000011;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("pre_abort_xy",  {30'd0, o_x, o_y}, 2);
    chk("pre_abort_err", o_err, inject[0] | inject[1]);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all_zero("abort");
    for (int k = 0; k < 10; k++) chk("abort_no_done", o_done, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 9) chk("abort_idle_busy", o_busy, 0);
      chk("abort_quiet_done", o_done, 0);
    end

    // Reset during a fresh run at vec=1.
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("rst_vec1_xy", {30'd0, o_x, o_y}, 1);
    rst_n = 1'b0;
    step();
    chk_all_zero("rst_vec1");
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rst_vec1_no_done", o_done, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
